// File: rtl/ospi_ram_target.sv
// Octal-SPI style RAM target: 5-byte header (cmd, size, addr[23:0]) followed by
// write data or, after DMY_CYC dummy edges, strobed read data.
module ospi_ram_target #(
    parameter int         ADDR_W    = 8,
    parameter int         DMY_CYC   = 2,
    parameter logic [7:0] CMD_WRITE = 8'hA0,
    parameter logic [7:0] CMD_READ  = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ncs,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       dqs_o,
    output logic       dqs_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DUMMY,
        WR,
        RD,
        WAIT
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cmd;
    logic [7:0]        r_remain;
    logic [1:0]        r_hdrCnt;
    logic [3:0]        r_dmyCnt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_blocked;
    logic [7:0]        r_dataO;
    logic              r_dataOe;
    logic              r_dqs;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];

    logic              w_wrEn;
    logic [7:0]        w_rdByte;

    assign w_wrEn   = reset_n && !ncs && (r_state == WR);
    assign w_rdByte = r_mem[r_ptr];

    // RAM contents survive reset; only writes in WR with the frame still open land.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cmd     <= 8'd0;
            r_remain  <= 8'd0;
            r_hdrCnt  <= 2'd0;
            r_dmyCnt  <= 4'd0;
            r_ptr     <= '0;
            r_dataO   <= 8'd0;
            r_dataOe  <= 1'b0;
            r_dqs     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            // A frame already in progress at reset release must be closed before the next one.
            r_blocked <= !ncs;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (ncs) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_dataOe  <= 1'b0;
                r_dqs     <= 1'b0;
                r_dataO   <= 8'd0;
                r_blocked <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!r_blocked) begin
                            r_cmd    <= data_i;
                            r_hdrCnt <= 2'd0;
                            r_state  <= HDR;
                            r_busy   <= 1'b1;
                        end
                    end
                    HDR: begin
                        r_hdrCnt <= r_hdrCnt + 2'd1;
                        if (r_hdrCnt == 2'd0) begin
                            r_remain <= data_i;
                        end else begin
                            // Address bytes shift in MSB first; bits above ADDR_W fall off the top.
                            r_ptr <= (r_ptr << 8) | ADDR_W'(data_i);
                        end
                        if (r_hdrCnt == 2'd3) begin
                            if (r_cmd == CMD_WRITE) begin
                                r_state <= WR;
                            end else if (r_cmd == CMD_READ) begin
                                r_dmyCnt <= 4'd0;
                                r_state  <= DUMMY;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= WAIT;
                            end
                        end
                    end
                    DUMMY: begin
                        if (r_dmyCnt == 4'(DMY_CYC - 1)) begin
                            r_dataO  <= w_rdByte;
                            r_dataOe <= 1'b1;
                            r_dqs    <= 1'b1;
                            r_ptr    <= r_ptr + ADDR_W'(1);
                            r_state  <= RD;
                        end else begin
                            r_dmyCnt <= r_dmyCnt + 4'd1;
                        end
                    end
                    RD: begin
                        if (r_remain == 8'd0) begin
                            r_dataOe <= 1'b0;
                            r_dqs    <= 1'b0;
                            r_dataO  <= 8'd0;
                            r_done   <= 1'b1;
                            r_state  <= WAIT;
                        end else begin
                            r_dataO  <= w_rdByte;
                            r_dqs    <= ~r_dqs;
                            r_ptr    <= r_ptr + ADDR_W'(1);
                            r_remain <= r_remain - 8'd1;
                        end
                    end
                    WR: begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                        if (r_remain == 8'd0) begin
                            r_done  <= 1'b1;
                            r_state <= WAIT;
                        end else begin
                            r_remain <= r_remain - 8'd1;
                        end
                    end
                    WAIT: begin
                        r_state <= WAIT;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_o  = r_dataO;
    assign data_oe = r_dataOe;
    assign dqs_o   = r_dqs;
    assign dqs_oe  = r_dataOe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_ospi_ram_target.sv
// Directed bench for ospi_ram_target: a byte-level RAM model feeds a queue of
// expected read bytes that is popped whenever the target drives the bus.
module tb_ospi_ram_target;

    localparam int DMY = 2;

    logic       clk;
    logic       reset_n;
    logic       ncs;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;
    logic       dqs_o;
    logic       dqs_oe;
    logic       busy;
    logic       done;
    logic       err;

    int         nChecks = 0;
    int         nErrors = 0;
    logic [7:0] tbMem [256];
    logic [7:0] expQ [$];

    ospi_ram_target #(
        .ADDR_W   (8),
        .DMY_CYC  (DMY),
        .CMD_WRITE(8'hA0),
        .CMD_READ (8'h20)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ncs    (ncs),
        .data_i (data_i),
        .data_o (data_o),
        .data_oe(data_oe),
        .dqs_o  (dqs_o),
        .dqs_oe (dqs_oe),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, return at next falling edge.
    task automatic applyStimulus(input logic n, input logic [7:0] d);
        ncs    = n;
        data_i = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_o"}, data_o, 8'h00);
        checkOutput({tag, "_data_oe"}, {7'd0, data_oe}, 8'h00);
        checkOutput({tag, "_dqs_o"}, {7'd0, dqs_o}, 8'h00);
        checkOutput({tag, "_dqs_oe"}, {7'd0, dqs_oe}, 8'h00);
        checkOutput({tag, "_busy"}, {7'd0, busy}, 8'h00);
        checkOutput({tag, "_done"}, {7'd0, done}, 8'h00);
        checkOutput({tag, "_err"}, {7'd0, err}, 8'h00);
    endtask

    task automatic sendHeader(input logic [7:0] cmd, input logic [7:0] size, input logic [7:0] addr);
        applyStimulus(1'b0, cmd);
        checkOutput("hdr_busy", {7'd0, busy}, 8'h01);
        applyStimulus(1'b0, size);
        applyStimulus(1'b0, 8'h12);
        applyStimulus(1'b0, 8'h34);
        applyStimulus(1'b0, addr);
    endtask

    task automatic writeTxn(input logic [7:0] size, input logic [7:0] addr, input int nSend,
                            input logic [7:0] base, input logic [7:0] step);
        logic [7:0] ptr;
        logic [7:0] d;
        sendHeader(8'hA0, size, addr);
        checkOutput("wr_hdr_oe", {7'd0, data_oe}, 8'h00);
        ptr = addr;
        for (int i = 0; i < nSend; i++) begin
            d = 8'(int'(base) + int'(step) * i);
            applyStimulus(1'b0, d);
            if (i <= int'(size)) begin
                tbMem[ptr] = d;
                ptr++;
            end
            checkOutput("wr_done", {7'd0, done}, {7'd0, (i == int'(size))});
            checkOutput("wr_oe", {7'd0, data_oe}, 8'h00);
        end
        applyStimulus(1'b1, 8'h00);
        checkOutput("wr_end_busy", {7'd0, busy}, 8'h00);
        checkOutput("wr_end_done", {7'd0, done}, 8'h00);
    endtask

    task automatic readTxn(input logic [7:0] size, input logic [7:0] addr, input int nBytes);
        logic [7:0] ptr;
        logic       expDqs;
        logic       expOe;
        logic [7:0] e;
        int         total;
        int         lastJ;
        ptr = addr;
        for (int i = 0; i <= int'(size); i++) begin
            expQ.push_back(tbMem[ptr]);
            ptr++;
        end
        sendHeader(8'h20, size, addr);
        expDqs = 1'b1;
        total  = DMY + int'(size) + 1;
        lastJ  = (nBytes > int'(size)) ? total : DMY - 1 + nBytes;
        for (int j = 1; j <= lastJ; j++) begin
            applyStimulus(1'b0, 8'h00);
            expOe = (j >= DMY) && (j <= DMY + int'(size));
            checkOutput("rd_oe", {7'd0, data_oe}, {7'd0, expOe});
            checkOutput("rd_dqs_oe", {7'd0, dqs_oe}, {7'd0, expOe});
            checkOutput("rd_done", {7'd0, done}, {7'd0, (j == total)});
            checkOutput("rd_busy", {7'd0, busy}, 8'h01);
            if (data_oe === 1'b1) begin
                nChecks++;
                assert (expQ.size() != 0)
                else begin
                    nErrors++;
                    $error("[TB] FAIL rd_scoreboard: observed extra byte %h, expected none", data_o);
                end
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("rd_data", data_o, e);
                    checkOutput("rd_dqs", {7'd0, dqs_o}, {7'd0, expDqs});
                    expDqs = ~expDqs;
                end
            end else begin
                checkOutput("rd_dqs_idle", {7'd0, dqs_o}, 8'h00);
            end
        end
        applyStimulus(1'b1, 8'h00);
        checkOutput("rd_end_oe", {7'd0, data_oe}, 8'h00);
        checkOutput("rd_end_dqs", {7'd0, dqs_o}, 8'h00);
        checkOutput("rd_end_done", {7'd0, done}, 8'h00);
        checkOutput("rd_end_busy", {7'd0, busy}, 8'h00);
        if (nBytes > int'(size)) begin
            checkOutput("rd_sb_left", 8'(expQ.size()), 8'h00);
        end
        expQ.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        ncs     = 1'b1;
        data_i  = 8'h00;
        @(negedge clk);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        checkAllZero("reset");
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'h00);

        $display("[TB] fill RAM");
        writeTxn(8'hFF, 8'h00, 256, 8'h05, 8'h07);

        $display("[TB] basic write/read at 0x10");
        writeTxn(8'h03, 8'h10, 4, 8'h11, 8'h11);
        readTxn(8'h03, 8'h10, 4);

        $display("[TB] wrapping write at 0xFF");
        writeTxn(8'h01, 8'hFF, 2, 8'hAA, 8'h11);
        readTxn(8'h01, 8'hFF, 2);
        readTxn(8'h02, 8'hFE, 3);

        $display("[TB] bytes beyond length ignored");
        writeTxn(8'h01, 8'h20, 4, 8'h60, 8'h01);
        readTxn(8'h03, 8'h20, 4);

        $display("[TB] unknown opcode");
        sendHeader(8'h55, 8'h03, 8'h40);
        checkOutput("err_pulse", {7'd0, err}, 8'h01);
        checkOutput("err_busy", {7'd0, busy}, 8'h01);
        checkOutput("err_oe", {7'd0, data_oe}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'hEE);
            checkOutput("err_after", {7'd0, err}, 8'h00);
            checkOutput("err_wait_busy", {7'd0, busy}, 8'h01);
            checkOutput("err_wait_oe", {7'd0, data_oe}, 8'h00);
        end
        applyStimulus(1'b1, 8'h00);
        checkOutput("err_end_busy", {7'd0, busy}, 8'h00);
        readTxn(8'h03, 8'h40, 4);

        $display("[TB] aborted read and write");
        readTxn(8'h07, 8'h10, 3);
        writeTxn(8'h07, 8'h30, 2, 8'hC0, 8'h01);
        readTxn(8'h03, 8'h2F, 4);

        $display("[TB] reset during read");
        sendHeader(8'h20, 8'h07, 8'h10);
        for (int k = 0; k < DMY + 1; k++) begin
            applyStimulus(1'b0, 8'h00);
        end
        checkOutput("rst_rd_oe_before", {7'd0, data_oe}, 8'h01);
        checkOutput("rst_rd_data_before", data_o, tbMem[8'h11]);
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00);
        checkAllZero("rst_rd");
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'h00);
        readTxn(8'h07, 8'h10, 8);

        $display("[TB] ncs held low through reset release");
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'hA0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'hA0);
        checkOutput("hold_busy0", {7'd0, busy}, 8'h00);
        applyStimulus(1'b0, 8'h03);
        checkOutput("hold_busy1", {7'd0, busy}, 8'h00);
        applyStimulus(1'b1, 8'h00);
        readTxn(8'h03, 8'h10, 4);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/ospi_ram_target.md
OSPI_RAM_TARGET -- requirements
Module: ospi_ram_target

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; depth 2^ADDR_W bytes.
REQ-002 Parameter DMY_CYC, default 2, read dummy cycles; legal range 1..15.
REQ-003 Parameter CMD_WRITE, default 8'hA0, write opcode.
REQ-004 Parameter CMD_READ, default 8'h20, read opcode.
REQ-005 clk  input  1  bus/system clock; all bus sampling on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 ncs  input  1  chip select, active low; frames one transaction.
REQ-008 data_i  input  8  bus byte in.
REQ-009 data_o  output  8  bus byte out (read data).
REQ-010 data_oe  output  1  high = block drives data bus.
REQ-011 dqs_o  output  1  read strobe.
REQ-012 dqs_oe  output  1  equals data_oe.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle pulse when last data byte completes.
REQ-015 err  output  1  one-cycle pulse on unknown opcode.

Function
REQ-016 States: IDLE, HDR, DUMMY, WR, RD, WAIT; all outputs registered.
REQ-017 IDLE: first edge with ncs=0 captures data_i as cmd, enters HDR (header byte 0).
REQ-018 HDR: next four ncs=0 edges capture size, addr[23:16], addr[15:8], addr[7:0], in that order.
REQ-019 Transfer length = size+1 bytes (1..256); start address = addr[ADDR_W-1:0]; upper address bits ignored.
REQ-020 After byte 4: cmd==CMD_WRITE -> WR; cmd==CMD_READ -> DUMMY; otherwise err pulse, -> WAIT.
REQ-021 WR: each edge writes data_i to ram[ptr], ptr increments modulo 2^ADDR_W; after size+1 writes, done pulse, -> WAIT.
REQ-022 DUMMY: exactly DMY_CYC edges, bus not driven; RAM prefetch of byte 0 occurs here.
REQ-023 RD: byte i = ram[start+i mod depth] valid on data_o with data_oe=1 from edge 5+DMY_CYC+i to following edge.
REQ-024 dqs_o = 1 for byte 0, inverts each subsequent byte; dqs_o=0 whenever data_oe=0.
REQ-025 After last read byte: data_oe=0 on next edge, done pulse coincident, -> WAIT.
REQ-026 WAIT: bus ignored, no RAM writes, no drive; ncs=1 -> IDLE next edge.
REQ-027 ncs=1 in any state: -> IDLE next edge, data_oe=0 next edge, no further writes, no done pulse; bytes already written persist.
REQ-028 Bytes beyond transfer length within same ncs frame ignored.
REQ-029 New transaction requires at least one edge with ncs=1 after previous frame.
REQ-030 RAM: single-port synchronous, 8-bit, write priority irrelevant (no read/write in same transaction).

Reset
REQ-031 reset_n=0 at edge: state=IDLE, data_o=0, data_oe=0, dqs_o=0, busy=0, done=0, err=0, counters cleared.
REQ-032 Reset mid-transaction aborts immediately; RAM contents not cleared; block requires ncs=1 edge before accepting a frame only if ncs held low through reset release (treated as WAIT).

Verification
REQ-033 Write A0,03,00,00,10, data 11,22,33,44 -> ram[10..13]=11,22,33,44; done pulse on 4th data edge.
REQ-034 Read 20,03,00,00,10 (DMY_CYC=2) -> data_oe high edges 7..10, data_o 11,22,33,44, dqs_o 1,0,1,0, done once.
REQ-035 Write A0,01,00,00,FF (ADDR_W=8), data AA,BB -> ram[FF]=AA, ram[00]=BB (wrap).
REQ-036 Opcode 55 -> err pulse after byte 4, no drive, no writes, busy until ncs=1.
REQ-037 Read length 8, ncs raised after 3rd data byte -> data_oe=0 next edge, no done; write aborted after 2 bytes -> only 2 RAM bytes changed.
REQ-038 reset_n=0 during RD -> all outputs 0 next edge; subsequent read returns prior RAM contents.
